trojan_seq_trigger: RTL and testbench

// Parametrised sequential Trojan trigger for the AES test designs. Watches a

---
 rtl/trojan_seq_trigger.sv | 109 ++++++++++
 tb/tb_trojan_seq_trigger.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trojan_seq_trigger.sv
// Sequential trigger: arms after an ordered sequence of NUM_STAGES patterns on
// the monitored state bus has completed COUNT_THRESH times.
module trojan_seq_trigger #(
    parameter int                          WIDTH        = 128,
    parameter int                          NUM_STAGES   = 4,
    parameter logic [NUM_STAGES*WIDTH-1:0] PATTERNS     = '0,
    parameter bit                          GAP_MODE     = 1'b0,
    parameter int                          COUNT_THRESH = 1,
    parameter bit                          STICKY       = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             state_valid,
    input  logic [WIDTH-1:0] state,
    output logic             tj_trig,
    output logic [3:0]       stage,
    output logic [7:0]       hit_count
);

    localparam logic [0:0] SEEK       = 1'b0;
    localparam logic [0:0] FIRED      = 1'b1;
    localparam logic [3:0] LAST_STAGE = 4'(NUM_STAGES - 1);
    localparam logic [8:0] THRESH     = 9'(COUNT_THRESH);

    // Pattern table padded to 16 entries so the 4-bit stage index is always in range.
    logic [WIDTH-1:0] pat [16];

    for (genvar k = 0; k < 16; k++) begin : g_pat
        if (k < NUM_STAGES) begin : g_used
            assign pat[k] = PATTERNS[k*WIDTH +: WIDTH];
        end else begin : g_unused
            assign pat[k] = '0;
        end
    end

    logic [0:0] fsm_q, fsm_d;
    logic [3:0] stage_q, stage_d;
    logic [7:0] hit_q, hit_d;
    logic       trig_q, trig_d;
    logic       match_cur, match_first, complete;
    logic [8:0] hit_inc;

    // An X on the bus makes these compares unknown, which falls into the mismatch path.
    assign match_cur   = (state == pat[stage_q]);
    assign match_first = (state == pat[0]);
    assign hit_inc     = {1'b0, hit_q} + 9'd1;

    always_comb begin
        fsm_d    = fsm_q;
        stage_d  = stage_q;
        hit_d    = hit_q;
        trig_d   = trig_q;
        complete = 1'b0;
        if (clear) begin
            fsm_d   = SEEK;
            stage_d = '0;
            hit_d   = '0;
            trig_d  = 1'b0;
        end else if (fsm_q == FIRED) begin
            if (!STICKY) begin
                fsm_d   = SEEK;
                stage_d = '0;
                hit_d   = '0;
                trig_d  = 1'b0;
            end
        end else if (state_valid) begin
            if (match_cur) begin
                if (stage_q == LAST_STAGE) complete = 1'b1;
                else                       stage_d  = stage_q + 4'd1;
            end else if (!GAP_MODE) begin
                // A broken run may itself be the start of a new one.
                if (match_first) begin
                    if (LAST_STAGE == 4'd0) complete = 1'b1;
                    else                    stage_d  = 4'd1;
                end else begin
                    stage_d = '0;
                end
            end
            if (complete) begin
                stage_d = '0;
                hit_d   = (hit_q == 8'hff) ? hit_q : hit_inc[7:0];
                if (hit_inc == THRESH) begin
                    trig_d = 1'b1;
                    fsm_d  = FIRED;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= SEEK;
            stage_q <= '0;
            hit_q   <= '0;
            trig_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            stage_q <= stage_d;
            hit_q   <= hit_d;
            trig_q  <= trig_d;
        end
    end

    assign tj_trig   = trig_q;
    assign stage     = stage_q;
    assign hit_count = hit_q;

endmodule

// File: tb/tb_trojan_seq_trigger.sv
// Bench for trojan_seq_trigger: three configurations share one stimulus stream
// and are compared against a sequence-progress reference model.
module tb_trojan_seq_trigger;

    localparam logic [127:0] P0 = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] P1 = 128'hffeeddcc_bbaa9988_77665544_33221100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         state_valid;
    logic [127:0] state;
    logic         trig_o  [3];
    logic [3:0]   stage_o [3];
    logic [7:0]   hit_o   [3];

    int cfg_gap    [3] = '{0, 1, 0};
    int cfg_sticky [3] = '{1, 1, 0};
    int cfg_thr    [3] = '{1, 1, 3};

    logic [127:0] seq [2];
    int  m_prog  [3];
    int  m_hits  [3];
    bit  m_fired [3];
    int  n_checks = 0;
    int  n_pass   = 0;

    always #5 clk = ~clk;

    trojan_seq_trigger #(.WIDTH(128), .NUM_STAGES(2), .PATTERNS({P1, P0}), .GAP_MODE(1'b0),
                         .COUNT_THRESH(1), .STICKY(1'b1)) u_gap0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .state_valid(state_valid), .state(state),
        .tj_trig(trig_o[0]), .stage(stage_o[0]), .hit_count(hit_o[0]));

    trojan_seq_trigger #(.WIDTH(128), .NUM_STAGES(2), .PATTERNS({P1, P0}), .GAP_MODE(1'b1),
                         .COUNT_THRESH(1), .STICKY(1'b1)) u_gap1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .state_valid(state_valid), .state(state),
        .tj_trig(trig_o[1]), .stage(stage_o[1]), .hit_count(hit_o[1]));

    trojan_seq_trigger #(.WIDTH(128), .NUM_STAGES(2), .PATTERNS({P1, P0}), .GAP_MODE(1'b0),
                         .COUNT_THRESH(3), .STICKY(1'b0)) u_cnt3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .state_valid(state_valid), .state(state),
        .tj_trig(trig_o[2]), .stage(stage_o[2]), .hit_count(hit_o[2]));

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_prog[i]  = 0;
            m_hits[i]  = 0;
            m_fired[i] = 1'b0;
        end
    endtask

    // Progress = how many leading patterns of the sequence have been matched so far.
    task automatic model_update();
        bit known;
        known = !$isunknown(state);
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                m_prog[i] = 0; m_hits[i] = 0; m_fired[i] = 1'b0;
            end else if (m_fired[i]) begin
                if (cfg_sticky[i] == 0) begin
                    m_prog[i] = 0; m_hits[i] = 0; m_fired[i] = 1'b0;
                end
            end else if (state_valid) begin
                if (known && state == seq[m_prog[i]]) begin
                    m_prog[i] = m_prog[i] + 1;
                    if (m_prog[i] == 2) begin
                        m_prog[i] = 0;
                        if (m_hits[i] < 255) m_hits[i] = m_hits[i] + 1;
                        if (m_hits[i] == cfg_thr[i]) m_fired[i] = 1'b1;
                    end
                end else if (cfg_gap[i] == 0) begin
                    m_prog[i] = (known && state == seq[0]) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [127:0] s, input logic c);
        @(negedge clk);
        state_valid = v;
        state       = s;
        clear       = c;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; state_valid = 1'b0; state = '0;
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            n_checks += 3;
            if (trig_o[i] !== 1'b0) $display("FAIL reset dut%0d tj_trig got %0b want 0", i, trig_o[i]); else n_pass++;
            if (stage_o[i] !== 4'd0) $display("FAIL reset dut%0d stage got %0d want 0", i, stage_o[i]); else n_pass++;
            if (hit_o[i] !== 8'd0) $display("FAIL reset dut%0d hit_count got %0d want 0", i, hit_o[i]); else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_seq_basic();
        logic [127:0] pats [2];
        pats[0] = P0; pats[1] = P1;
        for (int k = 0; k < 22; k++) begin
            if (k < 2) step(1'b1, pats[k], 1'b0);
            else       step(1'(k % 2), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
            for (int i = 0; i < 3; i++) begin
                n_checks += 3;
                if (trig_o[i] !== m_fired[i]) $display("FAIL basic dut%0d k%0d tj_trig got %0b want %0b", i, k, trig_o[i], m_fired[i]); else n_pass++;
                if (stage_o[i] !== 4'(m_prog[i])) $display("FAIL basic dut%0d k%0d stage got %0d want %0d", i, k, stage_o[i], m_prog[i]); else n_pass++;
                if (hit_o[i] !== 8'(m_hits[i])) $display("FAIL basic dut%0d k%0d hit_count got %0d want %0d", i, k, hit_o[i], m_hits[i]); else n_pass++;
            end
            n_checks++;
            if (k == 0 && stage_o[0] !== 4'd1) $display("FAIL basic_stage1 got %0d want 1", stage_o[0]);
            else if (k >= 1 && trig_o[0] !== 1'b1) $display("FAIL basic_trig_held k%0d got %0b want 1", k, trig_o[0]);
            else n_pass++;
        end
    endtask

    task automatic test_gap0();
        logic [127:0] pats [6];
        pats = '{P0, 128'h0, P1, P0, P0, P1};
        step(1'b0, '0, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, pats[k], 1'b0);
            for (int i = 0; i < 3; i++) begin
                n_checks += 3;
                if (trig_o[i] !== m_fired[i]) $display("FAIL gap0 dut%0d k%0d tj_trig got %0b want %0b", i, k, trig_o[i], m_fired[i]); else n_pass++;
                if (stage_o[i] !== 4'(m_prog[i])) $display("FAIL gap0 dut%0d k%0d stage got %0d want %0d", i, k, stage_o[i], m_prog[i]); else n_pass++;
                if (hit_o[i] !== 8'(m_hits[i])) $display("FAIL gap0 dut%0d k%0d hit_count got %0d want %0d", i, k, hit_o[i], m_hits[i]); else n_pass++;
            end
            n_checks++;
            if (trig_o[0] !== (k == 5)) $display("FAIL gap0_trig k%0d got %0b want %0b", k, trig_o[0], k == 5); else n_pass++;
        end
    endtask

    task automatic test_gap1();
        logic [127:0] pats [5];
        logic         vlds [5];
        pats = '{P0, 128'h0, 128'h5, P1, P1};
        vlds = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        step(1'b0, '0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(vlds[k], pats[k], 1'b0);
            for (int i = 0; i < 3; i++) begin
                n_checks += 3;
                if (trig_o[i] !== m_fired[i]) $display("FAIL gap1 dut%0d k%0d tj_trig got %0b want %0b", i, k, trig_o[i], m_fired[i]); else n_pass++;
                if (stage_o[i] !== 4'(m_prog[i])) $display("FAIL gap1 dut%0d k%0d stage got %0d want %0d", i, k, stage_o[i], m_prog[i]); else n_pass++;
                if (hit_o[i] !== 8'(m_hits[i])) $display("FAIL gap1 dut%0d k%0d hit_count got %0d want %0d", i, k, hit_o[i], m_hits[i]); else n_pass++;
            end
            n_checks++;
            if (trig_o[1] !== (k == 4)) $display("FAIL gap1_trig k%0d got %0b want %0b", k, trig_o[1], k == 4); else n_pass++;
        end
    endtask

    task automatic test_count();
        step(1'b0, '0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k < 8) step(1'b1, (k % 2 == 0) ? P0 : P1, 1'b0);
            else       step(1'b0, '0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                n_checks += 3;
                if (trig_o[i] !== m_fired[i]) $display("FAIL count dut%0d k%0d tj_trig got %0b want %0b", i, k, trig_o[i], m_fired[i]); else n_pass++;
                if (stage_o[i] !== 4'(m_prog[i])) $display("FAIL count dut%0d k%0d stage got %0d want %0d", i, k, stage_o[i], m_prog[i]); else n_pass++;
                if (hit_o[i] !== 8'(m_hits[i])) $display("FAIL count dut%0d k%0d hit_count got %0d want %0d", i, k, hit_o[i], m_hits[i]); else n_pass++;
            end
            n_checks++;
            if (trig_o[2] !== (k == 5)) $display("FAIL count_pulse k%0d got %0b want %0b", k, trig_o[2], k == 5); else n_pass++;
            if (k == 5) begin
                n_checks++;
                if (hit_o[2] !== 8'd3) $display("FAIL count_hit3 got %0d want 3", hit_o[2]); else n_pass++;
            end
            if (k == 6) begin
                n_checks++;
                if (hit_o[2] !== 8'd0) $display("FAIL count_rearm got %0d want 0", hit_o[2]); else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        for (int r = 0; r < 2; r++) begin
            step(1'b0, '0, 1'b1);
            step(1'b1, P0, 1'b0);
            if (r == 1) step(1'b1, P1, 1'b0);
            @(negedge clk);
            #2 rst_n = 1'b0;
            model_reset();
            #1;
            for (int i = 0; i < 3; i++) begin
                n_checks += 3;
                if (trig_o[i] !== 1'b0) $display("FAIL async_rst%0d dut%0d tj_trig got %0b want 0", r, i, trig_o[i]); else n_pass++;
                if (stage_o[i] !== 4'd0) $display("FAIL async_rst%0d dut%0d stage got %0d want 0", r, i, stage_o[i]); else n_pass++;
                if (hit_o[i] !== 8'd0) $display("FAIL async_rst%0d dut%0d hit_count got %0d want 0", r, i, hit_o[i]); else n_pass++;
            end
            @(negedge clk);
            rst_n = 1'b1;
        end
    endtask

    task automatic test_clear_collision();
        step(1'b0, '0, 1'b1);
        step(1'b1, P0, 1'b0);
        step(1'b1, P1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks += 2;
            if (trig_o[i] !== 1'b0) $display("FAIL clear_p1 dut%0d tj_trig got %0b want 0", i, trig_o[i]); else n_pass++;
            if (stage_o[i] !== 4'd0) $display("FAIL clear_p1 dut%0d stage got %0d want 0", i, stage_o[i]); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [127:0] s;
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: s = P0;
                4, 5, 6:    s = P1;
                7:          s = '0;
                8:          s = {$urandom, $urandom, $urandom, $urandom};
                default: begin
                    s = ($urandom_range(0, 1) == 0) ? P0 : P1;
                    s[$urandom_range(0, 127)] = 1'bx;
                end
            endcase
            step(1'($urandom_range(0, 3) != 0), s, 1'($urandom_range(0, 29) == 0));
            for (int i = 0; i < 3; i++) begin
                n_checks += 3;
                if (trig_o[i] !== m_fired[i]) $display("FAIL random dut%0d k%0d tj_trig got %0b want %0b", i, k, trig_o[i], m_fired[i]); else n_pass++;
                if (stage_o[i] !== 4'(m_prog[i])) $display("FAIL random dut%0d k%0d stage got %0d want %0d", i, k, stage_o[i], m_prog[i]); else n_pass++;
                if (hit_o[i] !== 8'(m_hits[i])) $display("FAIL random dut%0d k%0d hit_count got %0d want %0d", i, k, hit_o[i], m_hits[i]); else n_pass++;
            end
        end
    endtask

    initial begin
        seq[0] = P0;
        seq[1] = P1;
        test_reset();
        test_seq_basic();
        test_gap0();
        test_gap1();
        test_count();
        test_async_reset();
        test_clear_collision();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
